// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing for the Pong core: pixel enable, counters, syncs,
// game strobes and the score blink, all registered on CLOCK_50.
module vga_timing_gen #(
    parameter int   H_ACTIVE     = 640,
    parameter int   H_FP         = 16,
    parameter int   H_SYNC       = 96,
    parameter int   H_BP         = 48,
    parameter int   V_ACTIVE     = 480,
    parameter int   V_FP         = 10,
    parameter int   V_SYNC       = 2,
    parameter int   V_BP         = 33,
    parameter logic HS_POL       = 1'b0,
    parameter logic VS_POL       = 1'b0,
    parameter int   BLINK_FRAMES = 30
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    output logic       pix_en,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       active,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       line_start,
    output logic       frame_start,
    output logic       game_tick,
    output logic       blink
);

    localparam int         H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [9:0] next_h_s;
    logic [9:0] next_v_s;
    logic       active_s;
    logic       hs_s;
    logic       vs_s;
    logic       line_start_s;
    logic       frame_start_s;
    logic       game_tick_s;
    logic [7:0] blink_cnt_r;
    logic [7:0] blink_cnt_s;
    logic       blink_s;

    // Next raster position and everything decoded from it, so outputs line up with the counters.
    always_comb begin
        next_h_s      = h_count;
        next_v_s      = v_count;
        blink_cnt_s   = blink_cnt_r;
        blink_s       = blink;
        if (pix_en) begin
            if (h_count == H_LAST) begin
                next_h_s = 10'd0;
                if (v_count == V_LAST) begin
                    next_v_s = 10'd0;
                end else begin
                    next_v_s = v_count + 10'd1;
                end
            end else begin
                next_h_s = h_count + 10'd1;
                next_v_s = v_count;
            end
        end else begin
            next_h_s = h_count;
            next_v_s = v_count;
        end

        active_s      = (next_h_s < H_VIS) && (next_v_s < V_VIS);
        hs_s          = ((next_h_s >= HS_FIRST) && (next_h_s <= HS_LAST)) ? HS_POL : ~HS_POL;
        vs_s          = ((next_v_s >= VS_FIRST) && (next_v_s <= VS_LAST)) ? VS_POL : ~VS_POL;
        // Strobes only on the advancing edge, so they last one CLOCK_50 cycle.
        line_start_s  = pix_en && (next_h_s == 10'd0);
        frame_start_s = line_start_s && (next_v_s == 10'd0);
        game_tick_s   = line_start_s && (next_v_s == V_VIS);

        if (frame_start_s) begin
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_s = 8'd0;
                blink_s     = ~blink;
            end else begin
                blink_cnt_s = blink_cnt_r + 8'd1;
                blink_s     = blink;
            end
        end else begin
            blink_cnt_s = blink_cnt_r;
            blink_s     = blink;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            pix_en      <= 1'b0;
            h_count     <= H_LAST;
            v_count     <= V_LAST;
            active      <= 1'b0;
            VGA_HS      <= ~HS_POL;
            VGA_VS      <= ~VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            game_tick   <= 1'b0;
            blink       <= 1'b0;
            blink_cnt_r <= 8'd0;
        end else begin
            pix_en      <= ~pix_en;
            h_count     <= next_h_s;
            v_count     <= next_v_s;
            active      <= active_s;
            VGA_HS      <= hs_s;
            VGA_VS      <= vs_s;
            line_start  <= line_start_s;
            frame_start <= frame_start_s;
            game_tick   <= game_tick_s;
            blink       <= blink_s;
            blink_cnt_r <= blink_cnt_s;
        end
    end

endmodule
